mem_counter_fifo: RTL

- Parametrised successor of the single-pointer memory/address-counter block.
- Provides a DEPTH × DATA_W memory with independent write and read address counters, occupancy count, full/empty flags and sticky overflow/underflow error flags.
- Sits between a data source and the transfer controller in the memory-transfer path; the controller pushes words in and pops them out without tracking addresses itself.

---
 rtl/mem_counter_pkg.sv | 21 ++
 rtl/mem_counter_ram.sv | 33 +++
 rtl/mem_counter_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_counter_pkg.sv
// Shared defaults and helpers for the mem_counter_fifo slice.
// Parity storage is enabled by defining MEM_COUNTER_PARITY_EN.
package mem_counter_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int PAR_MAX_W  = 64;

    // Occupancy type for the default geometry; counts 0..DEPTH inclusive.
    typedef logic [$clog2(DEF_DEPTH):0] count_t;

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Even parity; zero-extension of narrower words leaves the result unchanged.
    function automatic logic parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_counter_ram.sv
// Falling-edge storage array: one write port, one registered read port.
// Width is set by the parent (DATA_W, or DATA_W+1 with MEM_COUNTER_PARITY_EN).
module mem_counter_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(negedge clock) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read register clears on reset so the FIFO output starts at zero.
    always_ff @(negedge clock) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_counter_fifo.sv
// DEPTH x DATA_W FIFO with address counters, occupancy, full/empty and sticky errors.
// Optional per-word even parity is enabled by defining MEM_COUNTER_PARITY_EN.
module mem_counter_fifo
    import mem_counter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              RdEn,
    output logic [DATA_W-1:0] Dout,
    output logic              DoutValid,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [ADDR_W-1:0] RdAddr,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Empty,
    output logic              OvfErr,
    output logic              UdfErr,
    output logic              ParityErr
);

    localparam int CNT_W = count_w(DEPTH);

`ifdef MEM_COUNTER_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic             push_ok;
    logic             pop_ok;
    logic [MEM_W-1:0] wdata;
    logic [MEM_W-1:0] rdata;

    assign Full    = (Count == CNT_W'(DEPTH));
    assign Empty   = (Count == '0);
    assign push_ok = WrEn && !Full;
    assign pop_ok  = RdEn && !Empty;

`ifdef MEM_COUNTER_PARITY_EN
    assign wdata     = {parity(PAR_MAX_W'(DataIn)), DataIn};
    assign ParityErr = rdata[DATA_W] ^ parity(PAR_MAX_W'(rdata[DATA_W-1:0]));
`else
    assign wdata     = DataIn;
    assign ParityErr = 1'b0;
`endif

    assign Dout = rdata[DATA_W-1:0];

    // Write is gated by Reset so an in-flight push on the reset edge is discarded.
    mem_counter_ram #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clock(clock),
        .rst  (Reset),
        .we   (push_ok && !Reset),
        .waddr(WrAddr),
        .wdata(wdata),
        .re   (pop_ok),
        .raddr(RdAddr),
        .rdata(rdata)
    );

    always_ff @(negedge clock) begin
        if (Reset) begin
            WrAddr    <= '0;
            RdAddr    <= '0;
            Count     <= '0;
            DoutValid <= 1'b0;
            OvfErr    <= 1'b0;
            UdfErr    <= 1'b0;
        end else begin
            DoutValid <= pop_ok;
            if (push_ok)
                WrAddr <= WrAddr + 1'b1;
            if (pop_ok)
                RdAddr <= RdAddr + 1'b1;
            if (push_ok && !pop_ok)
                Count <= Count + 1'b1;
            else if (pop_ok && !push_ok)
                Count <= Count - 1'b1;
            if (WrEn && Full)
                OvfErr <= 1'b1;
            if (RdEn && Empty)
                UdfErr <= 1'b1;
        end
    end

endmodule
